// File: rtl/coso_pkg.sv
// Shared constants for the coherent-sampling counter and its matching controller.
package coso_pkg;
  localparam int CS_CNT_LENGTH   = 16;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int DEBOUNCE_LOG    = 3;
endpackage

// File: rtl/edge_debouncer.sv
// Resynchronises the sampled beat and emits an accepted rising edge with a
// post-edge blanking window.
module edge_debouncer
  import coso_pkg::*;
#(
  parameter int DebounceCycles = DEBOUNCE_CYCLES,
  parameter int DebounceLog    = DEBOUNCE_LOG
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_beat,
  output logic o_edge
);

  localparam logic [DebounceLog-1:0] LP_DEB_LOAD = DebounceLog'(DebounceCycles);

  logic                   r_b1;
  logic                   r_b2;
  logic [DebounceLog-1:0] r_deb;
  logic                   w_rise;

  assign w_rise = r_b1 & ~r_b2;
  // Reset is folded in so nothing downstream reacts to an edge on a reset cycle.
  assign o_edge = w_rise & (r_deb == '0) & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_b1  <= 1'b0;
      r_b2  <= 1'b0;
      r_deb <= '0;
    end else begin
      r_b1 <= i_beat;
      r_b2 <= r_b1;
      if (o_edge) begin
        r_deb <= LP_DEB_LOAD;
      end else if (r_deb != '0) begin
        r_deb <= r_deb - DebounceLog'(1);
      end
    end
  end

endmodule

// File: rtl/coherent_sampler_counter.sv
// Measures beat periods in clk cycles and hands each one to a controller via
// a req/ack handshake, with a raw random bit taken from the period LSB.
module coherent_sampler_counter
  import coso_pkg::*;
#(
  parameter int CSCntLength    = CS_CNT_LENGTH,
  parameter int DebounceCycles = DEBOUNCE_CYCLES,
  parameter int DebounceLog    = DEBOUNCE_LOG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beat,
  input  logic                   CSAck,
  output logic [CSCntLength-1:0] CSCnt,
  output logic                   CSReq,
  output logic                   rndBit,
  output logic                   rndValid,
  output logic                   overrun
);

  localparam logic [CSCntLength-1:0] LP_ONES = '1;

  logic                   w_edge;
  logic                   w_sat;
  logic                   w_issue;
  logic [CSCntLength-1:0] r_period;
  logic [CSCntLength-1:0] r_cscnt;
  logic                   r_armed;
  logic                   r_await;
  logic                   r_req;
  logic                   r_rnd_bit;
  logic                   r_rnd_valid;
  logic                   r_overrun;

  edge_debouncer #(
    .DebounceCycles(DebounceCycles),
    .DebounceLog   (DebounceLog)
  ) u_edge_debouncer (
    .i_clk (clk),
    .i_rst (rst),
    .i_beat(beat),
    .o_edge(w_edge)
  );

  assign w_sat = (r_period == LP_ONES);

  // Handshake: CSReq is a single-cycle pulse that presents a new CSCnt and
  // opens an ack window; any cycle with CSAck high closes it. A new edge while
  // the window is open drops that period and pulses overrun instead. An ack on
  // the same cycle as an edge closes the old window before the new one opens.
  assign w_issue = w_edge & r_armed & (~r_await | CSAck);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= '0;
    end else if (w_edge) begin
      r_period <= CSCntLength'(1);
    end else if (!w_sat) begin
      r_period <= r_period + CSCntLength'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_await     <= 1'b0;
      r_cscnt     <= '0;
      r_req       <= 1'b0;
      r_rnd_bit   <= 1'b0;
      r_rnd_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_req       <= 1'b0;
      r_rnd_valid <= 1'b0;
      r_overrun   <= 1'b0;
      if (w_edge && !r_armed) begin
        r_armed <= 1'b1;
      end
      if (w_issue) begin
        r_cscnt <= r_period;
        r_req   <= 1'b1;
        r_await <= 1'b1;
        // A saturated count carries no entropy, so it is not offered as a bit.
        if (!w_sat) begin
          r_rnd_bit   <= r_period[0];
          r_rnd_valid <= 1'b1;
        end
      end else begin
        if (w_edge && r_armed) begin
          r_overrun <= 1'b1;
        end
        if (CSAck) begin
          r_await <= 1'b0;
        end
      end
    end
  end

  assign CSCnt    = r_cscnt;
  assign CSReq    = r_req;
  assign rndBit   = r_rnd_bit;
  assign rndValid = r_rnd_valid;
  assign overrun  = r_overrun;

endmodule

// File: doc/coherent_sampler_counter.md
COHERENT_SAMPLER_COUNTER -- requirements
Module: coherent_sampler_counter

Interface
REQ-001 The block SHALL have parameter CSCntLength, default 16: width of the period counter and of the CSCnt output.
REQ-002 The block SHALL have parameter DebounceCycles, default 4: number of cycles after an accepted beat edge during which further rising edges are ignored.
REQ-003 The block SHALL have parameter DebounceLog, default 3: width of the debounce counter; DebounceCycles SHALL be <= 2^DebounceLog-1.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, the sampling oscillator clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port beat, input, 1 bit: the sampled oscillator value, already captured by a clk flip-flop outside this block.
REQ-007 The block SHALL have port CSAck, input, 1 bit: acknowledge from the downstream controller.
REQ-008 The block SHALL have port CSCnt, output, CSCntLength bits: registered length of the last beat period, in clk cycles.
REQ-009 The block SHALL have port CSReq, output, 1 bit: one-cycle pulse that flags a new CSCnt.
REQ-010 The block SHALL have port rndBit, output, 1 bit: registered raw random bit, equal to CSCnt[0] of the last valid period.
REQ-011 The block SHALL have port rndValid, output, 1 bit: one-cycle strobe that qualifies rndBit.
REQ-012 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a period is dropped because the previous one was not yet acknowledged.

Function
REQ-013 beat SHALL pass through two registers, b1 and b2; rise = b1 & ~b2.
REQ-014 An accepted edge SHALL be a rise while the debounce counter is 0 and rst is low.
REQ-015 On an accepted edge the debounce counter SHALL load DebounceCycles; it SHALL decrement by 1 each cycle while it is nonzero.
REQ-016 The period counter SHALL load 1 on an accepted edge and otherwise increment by 1 each cycle, saturating at all-ones with no wrap.
REQ-017 The first accepted edge after reset SHALL only set an internal armed flag and restart the counter; it SHALL produce no CSReq, rndValid or overrun.
REQ-018 On an accepted edge while armed and not awaiting ack, on the same clock edge: CSCnt <= period counter value; CSReq <= 1 for one cycle; awaitAck <= 1.
REQ-019 Latency: beat first sampled high at clk edge t gives CSReq high and the new CSCnt after edge t+2.
REQ-020 rndBit <= period counter bit 0 and rndValid pulses with CSReq, except when the captured value is all-ones (saturated); then rndValid SHALL stay 0 and CSReq still pulses.
REQ-021 CSReq SHALL never be high for two consecutive cycles, because the controller counts every cycle in which CSReq is high.
REQ-022 awaitAck SHALL clear on any cycle in which CSAck = 1; CSAck while not awaiting ack SHALL be ignored.
REQ-023 An accepted edge while awaitAck = 1 and CSAck = 0: CSCnt, rndBit and awaitAck held; overrun pulses for one cycle; the period counter still restarts at 1.
REQ-024 An accepted edge in the same cycle as CSAck = 1: the ack is taken first, and a new CSReq is issued normally with no overrun.
REQ-025 Rises during debounce SHALL be ignored and SHALL NOT restart the period counter.
REQ-026 CSCnt SHALL be stable at all times other than the update edge in REQ-018.

Reset
REQ-027 rst high at any clock edge SHALL clear b1, b2, the period counter, the debounce counter, armed, awaitAck, CSCnt, CSReq, rndBit, rndValid and overrun to 0; this applies mid-period and mid-handshake.
REQ-028 After rst is released, the first accepted edge SHALL be treated per REQ-017.

Structure
REQ-029 Shared package coso_pkg SHALL hold CSCntLength and the debounce defaults, shared with the matching controller.
REQ-030 Sub-module edge_debouncer SHALL contain b1, b2, the debounce counter and the accepted-edge output; the period counter and handshake SHALL stay in the top level.

Verification
REQ-031 Bench SHALL cover: clean beat with period 100, CSAck returned 1 cycle after CSReq -> CSCnt = 100 each period, rndBit = 0, rndValid every period, no overrun, first period after reset silent.
REQ-032 Bench SHALL cover: beat pattern 1,0,1,1 at an edge with DebounceCycles = 4 -> exactly one accepted edge; next CSCnt unaffected by the bounce.
REQ-033 Bench SHALL cover: CSAck withheld over two periods of 57 -> second edge gives an overrun pulse and CSCnt stays at the first value; ack then a third period -> new CSReq with CSCnt = 57.
REQ-034 Bench SHALL cover: CSCntLength = 8, period 300 -> CSCnt = 255, CSReq pulses, rndValid = 0.
REQ-035 Bench SHALL cover: CSAck coinciding with an accepted edge -> CSReq issued, overrun = 0.
REQ-036 Bench SHALL cover: rst asserted mid-period while awaitAck = 1 -> all outputs 0 next cycle; first post-reset edge silent; second edge gives the correct period.
